// File: rtl/spi_slave_exch_byte.sv
// SPI mode-0 slave that exchanges BYTE-bit words with a master while oversampling
// the SPI pins in the clk_i domain, with a one-word TX holding register.
module spi_slave_exch_byte #(
  parameter int unsigned BYTE        = 8,
  parameter int unsigned SYNC_STAGES = 2   // must be >= 2
) (
  input  logic            clk_i,
  input  logic            arst_i,
  input  logic            sclk_i,
  input  logic            cs_n_i,
  input  logic            mosi_i,
  output logic            miso_o,
  output logic            miso_oe_o,
  input  logic            msb_lsb_sel_i,
  input  logic [BYTE-1:0] tx_data_i,
  input  logic            tx_valid_i,
  output logic            tx_ready_o,
  output logic [BYTE-1:0] rx_data_o,
  output logic            rx_valid_o,
  output logic            tx_underrun_o,
  output logic            abort_o,
  output logic            busy_o
);

  localparam int unsigned CntW = $clog2(BYTE) + 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(BYTE);
  localparam logic [CntW-1:0] CntLast = CntW'(BYTE - 1);

  typedef enum logic [1:0] {
    StateIdle,
    StateLoad,
    StateShift
  } state_e;

  function automatic logic [BYTE-1:0] f_bitrev(input logic [BYTE-1:0] v);
    logic [BYTE-1:0] r;
    for (int unsigned i = 0; i < BYTE; i++) begin
      r[i] = v[BYTE-1-i];
    end
    return r;
  endfunction

  // Input synchronizers
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_n_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_d;
  logic                   r_cs_n_d;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_sclk_sync <= '0;
      r_cs_n_sync <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_n_d    <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_i};
      r_cs_n_sync <= {r_cs_n_sync[SYNC_STAGES-2:0], cs_n_i};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_i};
      r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
      r_cs_n_d    <= r_cs_n_sync[SYNC_STAGES-1];
    end
  end

  logic w_sclk;
  logic w_cs_n;
  logic w_mosi;
  logic w_rise;
  logic w_fall;
  logic w_cs_fall;
  logic w_cs_rise;

  assign w_sclk    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_n    = r_cs_n_sync[SYNC_STAGES-1];
  assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise    = w_sclk & ~r_sclk_d;
  assign w_fall    = ~w_sclk & r_sclk_d;
  assign w_cs_fall = ~w_cs_n & r_cs_n_d;
  assign w_cs_rise = w_cs_n & ~r_cs_n_d;

  state_e            r_state;
  logic [CntW-1:0]   r_cnt;
  logic [BYTE-1:0]   r_rx_shift;
  logic [BYTE-1:0]   r_tx_shift;
  logic [BYTE-1:0]   r_tx_hold;
  logic              r_tx_ready;
  logic              r_rx_pend;
  logic              r_miso;
  logic              r_miso_oe;
  logic              r_busy;
  logic [BYTE-1:0]   r_rx_data;
  logic              r_rx_valid;
  logic              r_underrun;
  logic              r_abort;

  logic              w_word_done;
  logic              w_consume;
  logic [BYTE-1:0]   w_tx_word;

  // The BYTE-th rise completes the word even if cs_n rises in the same cycle.
  assign w_word_done = (r_state == StateShift) & w_rise & (r_cnt == CntLast);
  assign w_consume   = (r_state == StateLoad) & ~w_cs_rise & ~r_tx_ready;
  // The shift register always emits bit 0 first, so MSB-first needs a reversal.
  assign w_tx_word   = r_tx_ready    ? '1 :
                       msb_lsb_sel_i ? r_tx_hold : f_bitrev(r_tx_hold);

  // TX holding register; a same-cycle capture wins over the consume.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_tx_hold  <= '0;
      r_tx_ready <= 1'b1;
    end else begin
      if (w_consume) begin
        r_tx_ready <= 1'b1;
      end
      if (tx_valid_i && r_tx_ready) begin
        r_tx_hold  <= tx_data_i;
        r_tx_ready <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state    <= StateIdle;
      r_cnt      <= '0;
      r_rx_shift <= '0;
      r_tx_shift <= '1;
      r_rx_pend  <= 1'b0;
      r_miso     <= 1'b1;
      r_miso_oe  <= 1'b0;
      r_busy     <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
      r_abort    <= 1'b0;
      r_rx_pend  <= w_word_done;

      if (r_rx_pend) begin
        r_rx_data  <= msb_lsb_sel_i ? r_rx_shift : f_bitrev(r_rx_shift);
        r_rx_valid <= 1'b1;
      end

      unique case (r_state)
        StateIdle: begin
          r_miso <= 1'b1;
          if (w_cs_fall) begin
            r_state   <= StateLoad;
            r_miso_oe <= 1'b1;
            r_busy    <= 1'b1;
          end
        end

        StateLoad: begin
          if (w_cs_rise) begin
            r_state   <= StateIdle;
            r_miso    <= 1'b1;
            r_miso_oe <= 1'b0;
            r_busy    <= 1'b0;
          end else begin
            r_state    <= StateShift;
            r_tx_shift <= {1'b1, w_tx_word[BYTE-1:1]};
            r_miso     <= w_tx_word[0];
            r_underrun <= r_tx_ready;
            r_cnt      <= '0;
            r_rx_shift <= '0;
          end
        end

        StateShift: begin
          if (w_rise && (r_cnt != CntMax)) begin
            r_rx_shift <= {w_mosi, r_rx_shift[BYTE-1:1]};
            r_cnt      <= r_cnt + 1'b1;
          end
          if (w_cs_rise) begin
            r_state   <= StateIdle;
            r_miso    <= 1'b1;
            r_miso_oe <= 1'b0;
            r_busy    <= 1'b0;
            r_abort   <= (r_cnt != '0) && (r_cnt != CntMax) && !w_word_done;
          end else if (w_fall) begin
            if (r_cnt == CntMax) begin
              r_state <= StateLoad;
            end else begin
              r_miso     <= r_tx_shift[0];
              r_tx_shift <= {1'b1, r_tx_shift[BYTE-1:1]};
            end
          end
        end

        default: begin
          r_state   <= StateIdle;
          r_miso    <= 1'b1;
          r_miso_oe <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign miso_o        = r_miso;
  assign miso_oe_o     = r_miso_oe;
  assign tx_ready_o    = r_tx_ready;
  assign rx_data_o     = r_rx_data;
  assign rx_valid_o    = r_rx_valid;
  assign tx_underrun_o = r_underrun;
  assign abort_o       = r_abort;
  assign busy_o        = r_busy;

endmodule

// File: tb/tb_spi_slave_exch_byte.sv
// Scoreboard bench for spi_slave_exch_byte: a mode-0 master model drives directed words
// and pushes expected RX and MISO words; a monitor process pops and compares them.
module tb_spi_slave_exch_byte;

  localparam int Half = 5;  // sclk half period in clk_i cycles

  logic       clk = 1'b0;
  logic       arst;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic       msb_lsb_sel;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_underrun;
  logic       abort_p;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  int rx_cnt   = 0;
  int ur_cnt   = 0;
  int ab_cnt   = 0;

  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_miso_q[$];
  logic [7:0] obs_miso_q[$];

  spi_slave_exch_byte #(
    .BYTE       (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i        (clk),
    .arst_i       (arst),
    .sclk_i       (sclk),
    .cs_n_i       (cs_n),
    .mosi_i       (mosi),
    .miso_o       (miso),
    .miso_oe_o    (miso_oe),
    .msb_lsb_sel_i(msb_lsb_sel),
    .tx_data_i    (tx_data),
    .tx_valid_i   (tx_valid),
    .tx_ready_o   (tx_ready),
    .rx_data_o    (rx_data),
    .rx_valid_o   (rx_valid),
    .tx_underrun_o(tx_underrun),
    .abort_o      (abort_p),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_load(input logic [7:0] d);
    int t;
    t = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("tx_load_ready", {31'd0, tx_ready}, 32'd1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic select();
    cs_n = 1'b0;
    wait_clk(10);
  endtask

  // end_mode: 0 keep selected, 1 raise cs_n with the last fall, 2 raise cs_n with the last rise
  task automatic spi_xfer(input logic [7:0] d, input int nbits, input int end_mode,
                          output logic [7:0] m);
    m = '0;
    for (int i = 0; i < nbits; i++) begin
      int idx;
      idx  = msb_lsb_sel ? i : 7 - i;
      mosi = d[idx];
      wait_clk(Half);
      m[idx] = miso;
      sclk = 1'b1;
      if (end_mode == 2 && i == nbits - 1) cs_n = 1'b1;
      wait_clk(Half);
      sclk = 1'b0;
      if (end_mode == 1 && i == nbits - 1) cs_n = 1'b1;
    end
    wait_clk(4);
  endtask

  // Monitor: pulse counters and scoreboard comparisons.
  initial begin : monitor
    logic [7:0] o;
    forever begin
      @(negedge clk);
      if (!arst) begin
        if (rx_valid) begin
          rx_cnt++;
          if (exp_rx_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL rx_unexpected: got 0x%0h, expected no rx_valid", rx_data);
          end else begin
            check("rx_data", {24'd0, rx_data}, {24'd0, exp_rx_q.pop_front()});
          end
        end
        if (tx_underrun) ur_cnt++;
        if (abort_p) ab_cnt++;
        if (obs_miso_q.size() > 0) begin
          o = obs_miso_q.pop_front();
          if (exp_miso_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL miso_unexpected: got 0x%0h, expected no word", o);
          end else begin
            check("miso_word", {24'd0, o}, {24'd0, exp_miso_q.pop_front()});
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] m;
    logic [7:0] m1;
    logic [7:0] m2;
    arst        = 1'b1;
    sclk        = 1'b0;
    cs_n        = 1'b1;
    mosi        = 1'b0;
    msb_lsb_sel = 1'b0;
    tx_data     = '0;
    tx_valid    = 1'b0;
    wait_clk(3);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_miso", {31'd0, miso}, 32'd1);
    check("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_underrun", {31'd0, tx_underrun}, 32'd0);
    check("rst_abort", {31'd0, abort_p}, 32'd0);
    arst = 1'b0;
    wait_clk(4);

    // MSB-first exchange
    msb_lsb_sel = 1'b0;
    tx_load(8'hA5);
    check("hold_full", {31'd0, tx_ready}, 32'd0);
    exp_rx_q.push_back(8'h3C);
    exp_miso_q.push_back(8'hA5);
    select();
    check("sel_busy", {31'd0, busy}, 32'd1);
    check("sel_miso_oe", {31'd0, miso_oe}, 32'd1);
    check("sel_consumed", {31'd0, tx_ready}, 32'd1);
    spi_xfer(8'h3C, 8, 1, m);
    obs_miso_q.push_back(m);
    wait_clk(10);
    check("msb_oe_off", {31'd0, miso_oe}, 32'd0);
    check("msb_busy_off", {31'd0, busy}, 32'd0);
    check("msb_miso_idle", {31'd0, miso}, 32'd1);
    check("msb_rx_count", rx_cnt, 32'd1);
    check("msb_no_underrun", ur_cnt, 32'd0);

    // LSB-first exchange
    msb_lsb_sel = 1'b1;
    tx_load(8'h01);
    exp_rx_q.push_back(8'h80);
    exp_miso_q.push_back(8'h01);
    select();
    spi_xfer(8'h80, 8, 1, m);
    obs_miso_q.push_back(m);
    check("lsb_first_miso_bit", {31'd0, m[0]}, 32'd1);
    wait_clk(10);
    check("lsb_rx_count", rx_cnt, 32'd2);

    // Underrun
    msb_lsb_sel = 1'b0;
    exp_rx_q.push_back(8'h5A);
    exp_miso_q.push_back(8'hFF);
    select();
    check("ur_pulse_at_load", ur_cnt, 32'd1);
    spi_xfer(8'h5A, 8, 1, m);
    obs_miso_q.push_back(m);
    wait_clk(10);
    check("ur_single_pulse", ur_cnt, 32'd1);
    check("ur_rx_count", rx_cnt, 32'd3);

    // Two-byte burst, second word loaded during the first
    tx_load(8'h11);
    exp_rx_q.push_back(8'hDE);
    exp_rx_q.push_back(8'hAD);
    exp_miso_q.push_back(8'h11);
    exp_miso_q.push_back(8'h22);
    select();
    fork
      begin
        spi_xfer(8'hDE, 8, 0, m1);
        spi_xfer(8'hAD, 8, 1, m2);
      end
      begin
        wait_clk(20);
        tx_load(8'h22);
      end
    join
    obs_miso_q.push_back(m1);
    obs_miso_q.push_back(m2);
    wait_clk(10);
    check("burst_no_underrun", ur_cnt, 32'd1);
    check("burst_rx_count", rx_cnt, 32'd5);

    // Abort after 3 rises; a word loaded meanwhile is kept for the next selection
    tx_load(8'h77);
    select();
    tx_load(8'h66);
    spi_xfer(8'hF0, 3, 0, m);
    cs_n = 1'b1;
    wait_clk(10);
    check("abort_pulse", ab_cnt, 32'd1);
    check("abort_no_rx", rx_cnt, 32'd5);
    check("abort_oe_off", {31'd0, miso_oe}, 32'd0);
    check("abort_busy_off", {31'd0, busy}, 32'd0);
    check("abort_hold_kept", {31'd0, tx_ready}, 32'd0);
    exp_rx_q.push_back(8'h0F);
    exp_miso_q.push_back(8'h66);
    select();
    spi_xfer(8'h0F, 8, 1, m);
    obs_miso_q.push_back(m);
    wait_clk(10);
    check("after_abort_rx_count", rx_cnt, 32'd6);

    // Reset mid-byte
    tx_load(8'h99);
    select();
    spi_xfer(8'hFF, 5, 0, m);
    arst = 1'b1;
    cs_n = 1'b1;
    #1;
    check("mid_rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("mid_rst_miso", {31'd0, miso}, 32'd1);
    check("mid_rst_miso_oe", {31'd0, miso_oe}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("mid_rst_pulses", {29'd0, rx_valid, tx_underrun, abort_p}, 32'd0);
    wait_clk(3);
    arst = 1'b0;
    wait_clk(5);
    check("post_rst_abort", ab_cnt, 32'd1);
    check("post_rst_underrun", ur_cnt, 32'd1);
    tx_load(8'hC3);
    exp_rx_q.push_back(8'h4B);
    exp_miso_q.push_back(8'hC3);
    select();
    spi_xfer(8'h4B, 8, 1, m);
    obs_miso_q.push_back(m);
    wait_clk(10);
    check("post_rst_rx_count", rx_cnt, 32'd7);

    // cs_n rises together with the last sclk rise: word still delivered, no abort
    tx_load(8'hE7);
    exp_rx_q.push_back(8'h96);
    exp_miso_q.push_back(8'hE7);
    select();
    spi_xfer(8'h96, 8, 2, m);
    obs_miso_q.push_back(m);
    wait_clk(10);
    check("late_cs_rx_count", rx_cnt, 32'd8);
    check("late_cs_no_abort", ab_cnt, 32'd1);
    check("late_cs_busy_off", {31'd0, busy}, 32'd0);

    wait_clk(5);
    check("rx_queue_drained", exp_rx_q.size(), 32'd0);
    check("miso_queue_drained", exp_miso_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_exch_byte.md
SPI_SLAVE_EXCH_BYTE -- requirements
Module: spi_slave_exch_byte

Interface
REQ-001 Parameter BYTE, default 8: bits per exchanged word.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth for sclk_i, cs_n_i and mosi_i; minimum 2.
REQ-003 clk_i  in  1  system clock; the only clock, and every flop is clocked on its rising edge.
REQ-004 arst_i  in  1  asynchronous, active-high reset.
REQ-005 sclk_i  in  1  SPI clock from the master, asynchronous to clk_i; mode 0, idle low.
REQ-006 cs_n_i  in  1  chip select, active low, asynchronous.
REQ-007 mosi_i  in  1  serial data from the master, asynchronous.
REQ-008 miso_o  out  1  serial data to the master.
REQ-009 miso_oe_o  out  1  MISO output enable; high only while the slave is selected.
REQ-010 msb_lsb_sel_i  in  1  bit order: 0 = MSB first, 1 = LSB first; applies to both directions.
REQ-011 tx_data_i  in  BYTE  next word to transmit.
REQ-012 tx_valid_i  in  1  tx_data_i is valid.
REQ-013 tx_ready_o  out  1  the TX holding register is empty.
REQ-014 rx_data_o  out  BYTE  last completely received word.
REQ-015 rx_valid_o  out  1  one-cycle pulse: rx_data_o was updated.
REQ-016 tx_underrun_o  out  1  one-cycle pulse: a word started with the holding register empty.
REQ-017 abort_o  out  1  one-cycle pulse: cs_n_i deasserted mid-word.
REQ-018 busy_o  out  1  high while selected (any state other than StateIdle).

Function
REQ-019 sclk_i, cs_n_i and mosi_i shall pass through SYNC_STAGES flops; all logic uses the synchronized versions.
- Rise/fall events are derived by comparing the synchronized sclk with its one-cycle-delayed copy.
- Supported operating range: f(clk_i) >= 4 x f(sclk_i).
REQ-020 FSM states: StateIdle, StateLoad, StateShift.
REQ-021 StateIdle -> StateLoad on a synchronized cs_n falling edge.
REQ-022 StateLoad lasts exactly one cycle, then goes to StateShift.
- Holding register full: copy it to the shift register (bit-reversed when msb_lsb_sel_i=0), set tx_ready_o, drive miso_o with the first bit.
- Holding register empty: load all-ones and pulse tx_underrun_o.
- Clear the bit counter and the RX shift register.
REQ-023 In StateShift, on each sclk rise event: shift the synchronized mosi into the RX shift register (in at the MSB, shifting toward LSB) and increment the bit counter.
REQ-024 In StateShift, on each sclk fall event with bit counter < BYTE: drive miso_o with the next TX bit.
REQ-025 On the rise event that brings the bit counter to BYTE:
- The next cycle shall load rx_data_o (bit-reversed when msb_lsb_sel_i=0) and pulse rx_valid_o.
- The state returns to StateLoad on the following sclk fall event, so multi-byte transfers continue while cs_n stays low.
REQ-026 TX holding register:
- tx_valid_i && tx_ready_o captures tx_data_i and clears tx_ready_o on the next cycle.
- tx_ready_o is set when StateLoad consumes the register.
- tx_valid_i while tx_ready_o=0 is ignored.
REQ-027 Synchronized cs_n rising edge in any non-idle state -> StateIdle on the next cycle, with miso_oe_o=0.
- abort_o pulses if the bit counter is in 1..BYTE-1; the partial word is discarded and rx_valid_o is not pulsed.
- A held TX word is retained for the next selection.
REQ-028 If the cs_n rising edge and the BYTE-th rise event occur in the same cycle, the completed word shall be delivered (rx_valid_o pulses) and abort_o shall not pulse.
REQ-029 If a consuming StateLoad and a tx handshake occur in the same cycle, the new word shall be captured and tx_ready_o shall end low.
REQ-030 miso_oe_o = 1 in StateLoad and StateShift only; miso_o = 1 whenever miso_oe_o = 0.
REQ-031 Bit counter width is clog2(BYTE)+1; it never wraps within a word.

Reset
REQ-032 While arst_i is high:
- State = StateIdle; tx_ready_o=1; miso_o=1; all other outputs 0.
- rx_data_o and the holding register are cleared; synchronizers are cleared, with sclk=0 and cs_n=1.
REQ-033 arst_i asserted mid-transfer shall take effect immediately, with no pulse outputs; after release, the block waits for a new cs_n falling edge.

Verification
REQ-034 MSB-first exchange:
- Stimulus: load 0xA5, msb_lsb_sel_i=0, master sends 0x3C with 8 mode-0 clocks.
- Required: MISO carries 1,0,1,0,0,1,0,1; rx_data_o=0x3C with a single rx_valid_o pulse.
REQ-035 LSB-first exchange:
- Stimulus: load 0x01, msb_lsb_sel_i=1, master sends 0x80 LSB first.
- Required: first MISO bit 1; rx_data_o=0x80.
REQ-036 Underrun:
- Stimulus: no TX load, 1 byte clocked.
- Required: tx_underrun_o pulses once; MISO = 0xFF.
REQ-037 Two-byte burst:
- Stimulus: cs_n held low; 0x11 loaded, then 0x22 loaded during byte 1; master sends 0xDE, 0xAD.
- Required: two rx_valid_o pulses carrying 0xDE, 0xAD; MISO carries 0x11 then 0x22; no underrun.
REQ-038 Abort:
- Stimulus: cs_n deasserted after 3 sclk rises.
- Required: abort_o pulses; no rx_valid_o; miso_oe_o=0; busy_o=0.
REQ-039 Reset mid-byte:
- Stimulus: arst_i asserted after 5 bits.
- Required: outputs at REQ-032 values immediately; the next full byte is received correctly.
